aes_decipher_sched: RTL and testbench
=====================================

Name: aes_decipher_sched

Overview:
- Round sequencer and two-requester arbiter for the AES inverse-cipher datapath (AddRoundKey / InvShiftRows / InvSubBytes / InvMixColumns core).
- Accepts ciphertext blocks from two requesters over valid/ready, using round-robin arbitration.
- For each accepted block, drives the core's begin-round, round-key-enable, last-round and round-number controls, and the round-key index to the key store.
- Returns the plaintext, tagged with its requester ID, over an output valid/ready channel.

Parameters:
- NR, 10, number of cipher rounds (10/12/14 for AES-128/192/256); 4-bit round counter.
- DW, 128, block width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 block valid
- req0_ready  out  1  requester 0 accept
- req0_data  in  DW  requester 0 ciphertext
- req1_valid  in  1  requester 1 block valid
- req1_ready  out  1  requester 1 accept
- req1_data  in  DW  requester 1 ciphertext
- core_cipher_text  out  DW  latched ciphertext of the job in flight
- core_begin_round  out  1  initial AddRoundKey cycle (key NR)
- core_rkey_en  out  1  inverse-round cycle, core state register updates
- core_last_round  out  1  final round (InvMixColumns bypassed)
- core_round_num  out  4  current round, 0..NR
- key_idx  out  4  round-key index requested from key store, equal to NR-core_round_num
- core_plain_text  in  DW  core state/result
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_data  out  DW  plaintext
- out_tag  out  1  requester ID of out_data
- busy  out  1  state != IDLE

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - State goes to IDLE; round-robin pointer set to 0 (req0 preferred).
  - All outputs are 0, except key_idx=NR.
  - A job in flight is discarded and no output is produced.
- **States:** IDLE -> LOAD -> ROUND -> FINAL -> DONE -> IDLE.
- **IDLE:**
  - reqN_ready is combinational: IDLE && reqN_valid && (the other requester is not valid, or ptr==N).
  - On a handshake: latch reqN_data into core_cipher_text, latch tag=N, set ptr to the opposite of N, go to LOAD.
  - If neither requester is valid, stay in IDLE.
- **LOAD:** one cycle; core_begin_round=1, core_round_num=0, key_idx=NR. Then go to ROUND with round=1.
- **ROUND:**
  - core_rkey_en=1; round_num increments each cycle from 1 to NR-1.
  - When round_num==NR-1, go to FINAL at the next edge.
- **FINAL:**
  - core_rkey_en=1, core_last_round=1, core_round_num=NR, key_idx=0.
  - At the edge, capture core_plain_text into out_data, go to DONE.
- **DONE:**
  - out_valid=1; out_data and out_tag are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE; out_valid is deasserted the next cycle.
  - No grant occurs in the same cycle as the out handshake (one bubble).
- **Latency and throughput:**
  - Request handshake at cycle t gives out_valid at t+NR+2 (t+12 for NR=10).
  - Maximum throughput is one block per NR+3 cycles.
- **Backpressure:** out_ready low holds DONE indefinitely, both reqN_ready stay 0, and ptr does not change.
- **Fairness:**
  - Both requesters continuously valid are served alternately: 0,1,0,1...
  - A requester with no competitor is granted regardless of ptr.
- Control outputs are combinational decodes of the state register and round counter, with no glitch-sensitive use.
- NR values outside {10,12,14} are illegal; the implementation checks this at elaboration.

Optional Feature:
- Macro: AES_DEC_SCHED_PERF_EN
- **Defined:**
  - Adds output perf_blocks (32 bits), which counts completed out handshakes and wraps at 2^32.
  - Adds output perf_stall (32 bits), which counts DONE cycles with out_ready=0 and saturates at 0xFFFFFFFF.
  - Both counters clear on rst.
- **Undefined:** both ports are absent and no counter logic is built. All other behaviour is identical.

Decomposition:
- Package aes_dec_sched_pkg contains:
  - state enum: IDLE, LOAD, ROUND, FINAL, DONE
  - default NR constant (10)
  - round-number width (4)
  - tag width (1)
- Sub-module aes_rr_arb2: two-input round-robin arbiter.
  - Inputs: valid pair, enable.
  - Outputs: one-hot grant; pointer update on the accept pulse.
- The FSM, round counter and output register stay in aes_decipher_sched.

Test Plan:
1. FIPS-197 AES-128 vector, with the real core and key store on req0:
   - Stimulus: req0_data=69c4e0d86a7b0430d8cdb78070b4c55a.
   - Required: out_data=00112233445566778899aabbccddeeff, out_tag=0, exactly 12 cycles after the handshake.
   - Required: key_idx sequence 10,9,...,0 while core_round_num runs 0..10.
2. Contention:
   - Stimulus: req0_valid and req1_valid held high with four distinct blocks each.
   - Required: grants alternate 0,1,0,1...; each out_tag matches its data; no block is lost or duplicated.
3. Backpressure:
   - Stimulus: out_ready held low for 20 cycles in DONE.
   - Required: out_data stable, both reqN_ready=0, busy=1; one cycle after out_ready=1, out_valid=0.
4. Reset mid-job:
   - Stimulus: rst asserted while core_round_num=5.
   - Required: next cycle busy=0, all control outputs 0, key_idx=10, no out_valid.
   - Required: the subsequent job completes normally with ptr=0 priority.
5. NR=14:
   - Stimulus: one request.
   - Required: core_round_num runs 0..14, core_last_round only at 14, out_valid at handshake+16.
6. With AES_DEC_SCHED_PERF_EN:
   - Stimulus: three completed jobs with five total stall cycles.
   - Required: perf_blocks=3, perf_stall=5; both read 0 after rst.

Source files
------------

// File: rtl/aes_dec_sched_pkg.sv
// rtl/aes_dec_sched_pkg.sv - shared types and constants for the AES inverse-cipher round sequencer
// Contents: state_e FSM encoding, default round count, round-number and tag widths.
package aes_dec_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int NR_DEFAULT = 10;
    localparam int RND_W      = 4;
    localparam int TAG_W      = 1;

endpackage

// File: rtl/aes_rr_arb2.sv
// rtl/aes_rr_arb2.sv - two-input round-robin arbiter with registered priority pointer
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (pointer -> 0, req0 preferred)
//   valid_i[1:0]  request valids
//   en_i          grants allowed this cycle
//   accept_i      pulse when a grant is consumed; pointer moves away from the winner
//   grant_o[1:0]  one-hot grant (combinational)
module aes_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // ptr_q == 0 means requester 0 wins a tie, 1 means requester 1 wins.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o[0] = en_i && valid_i[0] && (!valid_i[1] || !ptr_q);
        grant_o[1] = en_i && valid_i[1] && (!valid_i[0] ||  ptr_q);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            // The winner loses priority: granting 0 hands the next tie to 1.
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_decipher_sched.sv
// rtl/aes_decipher_sched.sv - round sequencer and 2-requester arbiter for an AES inverse-cipher core
// Optional feature macro: AES_DEC_SCHED_PERF_EN (adds perf_blocks / perf_stall counters)
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0_*/req1_*                  ciphertext request channels (valid/ready/data)
//   core_cipher_text               ciphertext of the job in flight
//   core_begin_round               initial AddRoundKey cycle (key NR)
//   core_rkey_en                   inverse-round cycle, core state updates
//   core_last_round                final round, InvMixColumns bypassed
//   core_round_num, key_idx        current round and matching key index (NR - round)
//   core_plain_text                core result, captured in the final round
//   out_valid/out_ready/out_data/out_tag  plaintext result channel with requester ID
//   busy                           sequencer not idle
//   perf_blocks, perf_stall        (macro only) completed blocks, stalled DONE cycles
module aes_decipher_sched
    import aes_dec_sched_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int DW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_data,
    output logic [DW-1:0]    core_cipher_text,
    output logic             core_begin_round,
    output logic             core_rkey_en,
    output logic             core_last_round,
    output logic [RND_W-1:0] core_round_num,
    output logic [RND_W-1:0] key_idx,
    input  logic [DW-1:0]    core_plain_text,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_tag,
    output logic             busy
`ifdef AES_DEC_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_blocks,
    output logic [31:0]      perf_stall
`endif
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
        $error("aes_decipher_sched: NR must be 10, 12 or 14");
    end

    localparam logic [RND_W-1:0] NR_V = RND_W'(NR);

    state_e             state_q, state_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [TAG_W-1:0]   tag_q;
    logic [DW-1:0]      cipher_q;
    logic [DW-1:0]      out_q;
    logic [1:0]         grant;
    logic               take;

    aes_rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  ({req1_valid, req0_valid}),
        .en_i     (state_q == IDLE),
        .accept_i (take),
        .grant_o  (grant)
    );

    // Ready is the grant itself, so any grant is a completed handshake.
    assign take       = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // round_q is kept equal to the visible round number in every state:
    // 0 in IDLE/LOAD/DONE, 1..NR-1 in ROUND, NR in FINAL.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                round_d = '0;
                if (take) state_d = LOAD;
            end
            LOAD: begin
                state_d = ROUND;
                round_d = RND_W'(1);
            end
            ROUND: begin
                if (round_q == NR_V - RND_W'(1)) begin
                    state_d = FINAL;
                    round_d = NR_V;
                end else begin
                    round_d = round_q + RND_W'(1);
                end
            end
            FINAL: begin
                state_d = DONE;
                round_d = '0;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= '0;
            tag_q    <= '0;
            cipher_q <= '0;
            out_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            if (take) begin
                cipher_q <= grant[1] ? req1_data : req0_data;
                tag_q    <= TAG_W'(grant[1]);
            end
            if (state_q == FINAL) begin
                out_q <= core_plain_text;
            end
        end
    end

    assign core_cipher_text = cipher_q;
    assign core_begin_round = (state_q == LOAD);
    assign core_rkey_en     = (state_q == ROUND) || (state_q == FINAL);
    assign core_last_round  = (state_q == FINAL);
    assign core_round_num   = round_q;
    assign key_idx          = NR_V - round_q;
    assign out_valid        = (state_q == DONE);
    assign out_data         = out_q;
    assign out_tag          = tag_q;
    assign busy             = (state_q != IDLE);

`ifdef AES_DEC_SCHED_PERF_EN
    logic [31:0] blocks_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_q <= '0;
            stall_q  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                blocks_q <= blocks_q + 32'd1;
            end
            if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_blocks = blocks_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_aes_decipher_sched.sv
// tb/tb_aes_decipher_sched.sv - directed self-checking bench for aes_decipher_sched
module tb_aes_decipher_sched;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    // Stand-in core: final-round state is ciphertext ^ MASK (maps FIPS CT to FIPS PT),
    // any other round shows ~ciphertext so a mistimed capture is visible.
    localparam logic [127:0] MASK    = FIPS_CT ^ FIPS_PT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         r0v, r0_ready, r1v, r1_ready;
    logic [127:0] r0d, r1d, ct, pt, od;
    logic         br, rke, lr, ov, ordy, ot, busy;
    logic [3:0]   rn, ki;

    logic         b_r0v, b_r0_ready, b_r1_ready;
    logic [127:0] b_r0d, b_ct, b_pt, b_od;
    logic         b_br, b_rke, b_lr, b_ov, b_ordy, b_ot, b_busy;
    logic [3:0]   b_rn, b_ki;

`ifdef AES_DEC_SCHED_PERF_EN
    logic [31:0]  perf_blocks, perf_stall, b_perf_blocks, b_perf_stall;
`endif

    assign pt   = lr   ? (ct ^ MASK)   : ~ct;
    assign b_pt = b_lr ? (b_ct ^ MASK) : ~b_ct;

    aes_decipher_sched #(.NR(10), .DW(128)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0_ready), .req0_data(r0d),
        .req1_valid(r1v), .req1_ready(r1_ready), .req1_data(r1d),
        .core_cipher_text(ct), .core_begin_round(br), .core_rkey_en(rke),
        .core_last_round(lr), .core_round_num(rn), .key_idx(ki),
        .core_plain_text(pt), .out_valid(ov), .out_ready(ordy),
        .out_data(od), .out_tag(ot), .busy(busy)
`ifdef AES_DEC_SCHED_PERF_EN
        , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
    );

    aes_decipher_sched #(.NR(14), .DW(128)) dut14 (
        .clk(clk), .rst(rst),
        .req0_valid(b_r0v), .req0_ready(b_r0_ready), .req0_data(b_r0d),
        .req1_valid(1'b0), .req1_ready(b_r1_ready), .req1_data(128'h0),
        .core_cipher_text(b_ct), .core_begin_round(b_br), .core_rkey_en(b_rke),
        .core_last_round(b_lr), .core_round_num(b_rn), .key_idx(b_ki),
        .core_plain_text(b_pt), .out_valid(b_ov), .out_ready(b_ordy),
        .out_data(b_od), .out_tag(b_ot), .busy(b_busy)
`ifdef AES_DEC_SCHED_PERF_EN
        , .perf_blocks(b_perf_blocks), .perf_stall(b_perf_stall)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef AES_DEC_SCHED_PERF_EN
    task automatic do_job(input int rq, input logic [127:0] d, input int stall);
        ordy = 1'b0;
        if (rq == 0) begin r0v = 1'b1; r0d = d; end
        else         begin r1v = 1'b1; r1d = d; end
        tick();
        r0v = 1'b0;
        r1v = 1'b0;
        for (int n = 0; n < 40 && !ov; n++) tick();
        chk("job_ov", ov, 1'b1);
        repeat (stall) tick();
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
    endtask
`endif

    logic [127:0] d0 [5];
    logic [127:0] d1 [5];
    logic [127:0] hold;
    int           i0, i1, nout, lat;
    logic         saw_ov;

    initial begin
        rst = 1'b1; r0v = 1'b0; r1v = 1'b0; r0d = '0; r1d = '0; ordy = 1'b0;
        b_r0v = 1'b0; b_r0d = '0; b_ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d0[i] = {32'hA0A0_A0A0, 64'h0, 32'(i)};
            d1[i] = {32'hB1B1_B1B1, 64'h0, 32'(i)};
        end

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_kidx", ki, 4'd10);
        chk("rst_ov",   ov, 1'b0);
        chk("rst_br",   br, 1'b0);
        chk("rst_rke",  rke, 1'b0);
        chk("rst_lr",   lr, 1'b0);
        chk("rst_rn",   rn, 4'd0);
        chk("rst_od",   od, 128'h0);
        chk("rst_ot",   ot, 1'b0);
        chk("rst_ct",   ct, 128'h0);
        chk("rst_kidx14", b_ki, 4'd14);
        rst = 1'b0;

        // 1: FIPS-197 vector on req0, round/key sequence and 12-cycle latency
        ordy = 1'b1; r0v = 1'b1; r0d = FIPS_CT;
        #1;
        chk("t1_rdy0", r0_ready, 1'b1);
        tick();
        r0v = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 11) begin
                chk("t1_rn",   rn, 128'(k - 1));
                chk("t1_kidx", ki, 128'(11 - k));
                chk("t1_ov",   ov, 1'b0);
            end
            chk("t1_br",  br,  k == 1);
            chk("t1_lr",  lr,  k == 11);
            chk("t1_rke", rke, (k >= 2) && (k <= 11));
            if (k == 12) begin
                chk("t1_ov12", ov, 1'b1);
                chk("t1_od",   od, FIPS_PT);
                chk("t1_ot",   ot, 1'b0);
                chk("t1_ct",   ct, FIPS_CT);
            end else begin
                tick();
            end
        end
        tick();
        chk("t1_ov_clr", ov, 1'b0);
        chk("t1_idle",   busy, 1'b0);

        // 2: contention, pointer now favours req1 so order is 1,0,1,0...
        i0 = 0; i1 = 0; nout = 0;
        for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
            r0v = (i0 < 4); r0d = d0[i0];
            r1v = (i1 < 4); r1d = d1[i1];
            #1;
            if (r0_ready && r1_ready) chk("t2_onehot", 2'b11, 2'b01);
            if (r0_ready) i0++;
            if (r1_ready) i1++;
            if (ov) begin
                chk("t2_tag",  ot, (nout % 2 == 0) ? 1'b1 : 1'b0);
                chk("t2_data", od, ((nout % 2 == 0) ? d1[nout / 2] : d0[nout / 2]) ^ MASK);
                nout++;
            end
            tick();
        end
        r0v = 1'b0; r1v = 1'b0;
        chk("t2_count", nout, 8);

        // 3: backpressure; last grant was req0 so req1 wins the tie
        ordy = 1'b0;
        r0v = 1'b1; r0d = 128'hC0DE_0000_0000_0000_0000_0000_0000_0030;
        r1v = 1'b1; r1d = 128'hC0DE_0000_0000_0000_0000_0000_0000_0031;
        #1;
        chk("t3_g1", r1_ready, 1'b1);
        chk("t3_g0", r0_ready, 1'b0);
        tick();
        r1v = 1'b0;
        for (int n = 0; n < 30 && !ov; n++) tick();
        chk("t3_ov", ov, 1'b1);
        chk("t3_ot", ot, 1'b1);
        hold = r1d ^ MASK;
        chk("t3_od", od, hold);
        r1v = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("t3_hold_od", od, hold);
            chk("t3_rdy0",    r0_ready, 1'b0);
            chk("t3_rdy1",    r1_ready, 1'b0);
            chk("t3_busy",    busy, 1'b1);
            chk("t3_ov_hold", ov, 1'b1);
        end
        ordy = 1'b1;
        tick();
        chk("t3_ov_clr", ov, 1'b0);
        chk("t3_ptr0",   r0_ready, 1'b1);
        chk("t3_ptr1",   r1_ready, 1'b0);
        r0v = 1'b0; r1v = 1'b0;
        tick();

        // 4: reset mid-job; lone req1 wins despite ptr favouring req0
        r1v = 1'b1; r1d = 128'hDEAD_BEEF;
        #1;
        chk("t4_lone1", r1_ready, 1'b1);
        tick();
        r1v = 1'b0;
        for (int n = 0; n < 20 && rn != 4'd5; n++) tick();
        chk("t4_rn5", rn, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_busy", busy, 1'b0);
        chk("t4_br",   br, 1'b0);
        chk("t4_rke",  rke, 1'b0);
        chk("t4_lr",   lr, 1'b0);
        chk("t4_rn",   rn, 4'd0);
        chk("t4_kidx", ki, 4'd10);
        chk("t4_ov",   ov, 1'b0);
        saw_ov = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            saw_ov = saw_ov | ov;
        end
        chk("t4_no_ov", saw_ov, 1'b0);
        r0v = 1'b1; r0d = 128'h1234_5678;
        r1v = 1'b1; r1d = 128'h8765_4321;
        #1;
        chk("t4_prio0", r0_ready, 1'b1);
        chk("t4_prio1", r1_ready, 1'b0);
        tick();
        r0v = 1'b0; r1v = 1'b0;
        lat = 1;
        while (!ov && lat < 30) begin
            tick();
            lat++;
        end
        chk("t4_lat", lat, 12);
        chk("t4_od",  od, 128'h1234_5678 ^ MASK);
        chk("t4_ot",  ot, 1'b0);
        tick();

        // 5: NR=14 instance
        b_ordy = 1'b1; b_r0v = 1'b1; b_r0d = FIPS_CT;
        #1;
        chk("t5_rdy", b_r0_ready, 1'b1);
        tick();
        b_r0v = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 15) begin
                chk("t5_rn",   b_rn, 128'(k - 1));
                chk("t5_kidx", b_ki, 128'(15 - k));
                chk("t5_lr",   b_lr, k == 15);
                chk("t5_ov",   b_ov, 1'b0);
                tick();
            end else begin
                chk("t5_ov16", b_ov, 1'b1);
                chk("t5_od",   b_od, FIPS_PT);
            end
        end
        tick();
        chk("t5_ov_clr", b_ov, 1'b0);

`ifdef AES_DEC_SCHED_PERF_EN
        // 6: performance counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_blk_rst0", perf_blocks, 32'd0);
        chk("t6_stl_rst0", perf_stall, 32'd0);
        do_job(0, 128'h11, 2);
        do_job(1, 128'h22, 0);
        do_job(0, 128'h33, 3);
        chk("t6_blocks", perf_blocks, 32'd3);
        chk("t6_stall",  perf_stall, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_blk_rst", perf_blocks, 32'd0);
        chk("t6_stl_rst", perf_stall, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
